// File: rtl/fetch_stage.sv
// IF-stage fetch unit: owns the PC and runs a request/ready handshake with instruction memory.
// Delivers PCPlus4F/InstrF to IF/ID and obeys the same stall/branch/jump controls as IF/ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic        JumpD,
    input  logic [31:0] PCBranchD,
    input  logic [31:0] PCJumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic [31:0] InstrF,
    output logic        FetchBusyF
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr_buf;
    logic        redir_pend;
    logic [31:0] redir_tgt;

    logic        redirect;
    logic [31:0] target;
    logic        deliver;

    // Jump wins over branch; targets are always word aligned.
    assign redirect = JumpD | PCSrcD;
    assign target   = JumpD ? {PCJumpD[31:2], 2'b00} : {PCBranchD[31:2], 2'b00};

    // A completed fetch is handed to IF/ID only if no redirect is pending or arriving.
    assign deliver  = (state == REQ) && imem_ready && !(redir_pend || redirect);

    // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        InstrF = 32'h0000_0000;
        if (deliver) begin
            InstrF = imem_rdata;
        end else if (state == HOLD) begin
            InstrF = instr_buf;
        end
    end

    assign imem_req   = (state == REQ);
    assign imem_addr  = pc;
    assign PCF        = pc;
    assign PCPlus4F   = pc + 32'd4;
    assign FetchBusyF = (state == REQ) && !imem_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr_buf  <= 32'h0000_0000;
            redir_pend <= 1'b0;
            redir_tgt  <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (!imem_ready) begin
                        // Redirects seen while waiting are remembered; the latest one wins.
                        if (redirect) begin
                            redir_pend <= 1'b1;
                            redir_tgt  <= target;
                        end
                    end else if (redir_pend || redirect) begin
                        pc         <= redirect ? target : redir_tgt;
                        redir_pend <= 1'b0;
                    end else if (StallF) begin
                        instr_buf <= imem_rdata;
                        state     <= HOLD;
                    end else begin
                        pc <= pc + 32'd4;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= REQ;
                    end else if (!StallF) begin
                        pc    <= pc + 32'd4;
                        state <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF-stage producer for the IF/ID pipeline register. It owns the PC register and runs a request/ready handshake with instruction memory. It delivers PCPlus4F/InstrF to IF/ID each cycle and obeys the same stall, branch and jump controls that IF/ID obeys. Memory wait states are reported to the hazard unit through FetchBusyF.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (low 2 bits must be 0)

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous, active-high reset
StallF  input  1  hazard unit: hold current PC/instruction
PCSrcD  input  1  branch taken in D; redirect to PCBranchD
JumpD  input  1  jump in D; redirect to PCJumpD
PCBranchD  input  32  branch target
PCJumpD  input  32  jump target
imem_req  output  1  instruction fetch request
imem_addr  output  32  fetch address (= PCF)
imem_ready  input  1  single-cycle pulse; imem_rdata valid in the same cycle
imem_rdata  input  32  fetched instruction word
PCF  output  32  current fetch PC
PCPlus4F  output  32  PCF + 4, combinational, wraps mod 2^32
InstrF  output  32  instruction presented to IF/ID (32'b0 = bubble)
FetchBusyF  output  1  request outstanding, no data this cycle

Behaviour:
- Reset state: in any cycle with rst=1, next state is IDLE and PCF=RESET_PC. Also cleared: instr_buf=0, redir_pend=0, redir_tgt=0. Outputs then read imem_req=0, InstrF=0, FetchBusyF=0, PCPlus4F=RESET_PC+4.
- Reset mid-request: the outstanding transaction is abandoned. An imem_ready arriving in IDLE is ignored.
- Target alignment: every loaded target is stored as {tgt[31:2],2'b00}.
- Redirect target: JumpD has priority over PCSrcD when both are high; target = JumpD ? PCJumpD : PCBranchD.
- IDLE: imem_req=0, InstrF=0. Always moves to REQ on the next cycle.
- REQ: imem_req=1, imem_addr=PCF. The request is held until imem_ready; it is never withdrawn.
  - imem_ready=0: FetchBusyF=1, InstrF=0. If a redirect is seen: redir_pend<=1, redir_tgt<=target. A later redirect overwrites an earlier one (last wins). Stay in REQ.
  - imem_ready=1 and (redir_pend or a redirect this cycle): InstrF=0 and the returned data is discarded. PCF<=target, using the current-cycle redirect if present, else redir_tgt. Clear redir_pend; stay in REQ.
  - imem_ready=1, no redirect, StallF=1: InstrF=imem_rdata, instr_buf<=imem_rdata, PCF held, go to HOLD.
  - imem_ready=1, no redirect, StallF=0: InstrF=imem_rdata, PCF<=PCF+4, stay in REQ. Back-to-back fetches give one instruction per cycle.
- HOLD: imem_req=0, FetchBusyF=0, InstrF=instr_buf.
  - Redirect: PCF<=target, go to REQ. Redirect beats StallF.
  - Else StallF=0: PCF<=PCF+4, go to REQ.
  - Else: stay in HOLD.
- Latency: with a zero-wait memory, the address is presented in cycle N and InstrF is valid in cycle N (combinational from imem_rdata). IF/ID captures it at the end of cycle N.
- Wrap-around: PCF=32'hFFFF_FFFC advances to 32'h0000_0000, and PCPlus4F wraps the same way.
- Simultaneous events: rst beats everything. Then redirect beats StallF. Then StallF beats advance.
- FetchBusyF = (state==REQ) & ~imem_ready. It is purely combinational, with no dependence on StallF or redirect.

Test Plan:
- Reset then zero-wait memory (ready=1 every REQ cycle), rdata=addr|1: after IDLE, PCF steps 0,4,8,C on consecutive cycles. InstrF=1,5,9,D and PCPlus4F=4,8,C,10 alongside.
- Memory with 2 wait cycles at PCF=8: FetchBusyF=1 and InstrF=0 for 2 cycles, imem_addr held at 8. Ready cycle gives InstrF=rdata, FetchBusyF=0, and PCF=C next cycle.
- StallF=1 for 3 cycles while the fetch at PCF=10 completes (rdata=32'h2002_0005): enters HOLD. InstrF stays 32'h2002_0005, imem_req=0 and PCF=10 for all 3 cycles; after release PCF=14.
- PCSrcD=1, PCBranchD=40 during a wait cycle, then JumpD=1, PCJumpD=80 one cycle later, ready 2 cycles after: returned data discarded (InstrF=0). Next PCF=80 (last wins); PCBranchD=43 in a separate test loads 40.
- In HOLD, StallF=1 with JumpD=1 and PCJumpD=100 in the same cycle: PCF=100 next cycle and state REQ. Separately, PCF=FFFF_FFFC with ready=1 -> next PCF=0.
- rst=1 for one cycle while REQ is waiting, then ready arrives in IDLE: ready ignored, PCF=RESET_PC, fetch restarts at RESET_PC.
